// File: rtl/ad7673_conv_sequencer.sv
`timescale 1ns/1ps
// Purpose: periodic AD7673 conversion sequencer; drives CNVST_N, tracks BUSY with a timeout,
//          and converts the 18-bit two's-complement result to an offset-binary sample.
// Latency: sample_valid rises 1 cycle after LATCH (BUSY fall plus 2 sync flops plus LATCH).
// Backpressure: one-entry valid/ready output; a new sample arriving while the held sample
//               is stalled is dropped and flags overrun.
//
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   enable               run periodic conversions (interval counter held at 0 when low)
//   clear_err            pulse clears the sticky overrun / timeout_err flags
//   BUSY, AD7673_DATA    ADC handshake (async, synchronised here) and parallel result
//   CNVST_N              registered convert-start strobe, active low
//   sample_data/_valid   offset-binary sample; sample_ready accepts it
//   overrun              sticky: tick missed or sample dropped
//   timeout_err          sticky: BUSY did not toggle within BUSY_TIMEOUT_CLK cycles
module ad7673_conv_sequencer #(
    parameter int SAMPLE_INTERVAL_CLK = 3000,
    parameter int CNVST_LOW_CLK       = 4,
    parameter int BUSY_TIMEOUT_CLK    = 200,
    parameter int OUT_WIDTH           = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 clear_err,
    input  logic                 BUSY,
    input  logic [17:0]          AD7673_DATA,
    output logic                 CNVST_N,
    output logic [OUT_WIDTH-1:0] sample_data,
    output logic                 sample_valid,
    input  logic                 sample_ready,
    output logic                 overrun,
    output logic                 timeout_err
);

    localparam int IW = (SAMPLE_INTERVAL_CLK > 1) ? $clog2(SAMPLE_INTERVAL_CLK) : 1;
    localparam int LW = $clog2(CNVST_LOW_CLK + 1);
    localparam int TW = $clog2(BUSY_TIMEOUT_CLK + 1);

    localparam logic [IW-1:0] IVL_LAST = IW'(SAMPLE_INTERVAL_CLK - 1);
    localparam logic [LW-1:0] LOW_LAST = LW'(CNVST_LOW_CLK - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(BUSY_TIMEOUT_CLK - 1);

    typedef enum logic [2:0] {
        IDLE,
        CONV_LOW,
        WAIT_RISE,
        WAIT_FALL,
        LATCH
    } state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          ivl_cnt_q, ivl_cnt_d;
    logic [LW-1:0]          low_cnt_q, low_cnt_d;
    logic [TW-1:0]          to_cnt_q, to_cnt_d;
    logic                   busy_meta_q, busy_meta_d;
    logic                   busy_s_q, busy_s_d;
    logic                   cnvst_n_q, cnvst_n_d;
    logic [OUT_WIDTH-1:0]   sample_data_q, sample_data_d;
    logic                   sample_valid_q, sample_valid_d;
    logic                   overrun_q, overrun_d;
    logic                   timeout_err_q, timeout_err_d;

    logic                   tick;
    logic                   tick_miss;
    logic                   timeout_evt;
    logic                   new_sample;
    logic                   drop;
    logic                   xfer;
    logic [OUT_WIDTH-1:0]   conv_sample;
    logic                   data_unused;

    // Low result bits below the output width are truncated, not rounded.
    assign data_unused = ^AD7673_DATA;
    assign conv_sample = {~AD7673_DATA[17], AD7673_DATA[16 -: OUT_WIDTH-1]};

    always_comb begin
        busy_meta_d = BUSY;
        busy_s_d    = busy_meta_q;

        // Interval counter: tick on the SAMPLE_INTERVAL_CLK-th enabled cycle, then wrap.
        tick      = enable && (ivl_cnt_q == IVL_LAST);
        ivl_cnt_d = (!enable || tick) ? '0 : ivl_cnt_q + 1'b1;

        state_d     = state_q;
        low_cnt_d   = low_cnt_q;
        to_cnt_d    = to_cnt_q;
        cnvst_n_d   = cnvst_n_q;
        timeout_evt = 1'b0;
        new_sample  = 1'b0;

        case (state_q)
            IDLE: begin
                cnvst_n_d = 1'b1;
                if (tick) begin
                    state_d   = CONV_LOW;
                    cnvst_n_d = 1'b0;
                    low_cnt_d = '0;
                end
            end
            CONV_LOW: begin
                if (low_cnt_q == LOW_LAST) begin
                    state_d   = WAIT_RISE;
                    cnvst_n_d = 1'b1;
                    to_cnt_d  = '0;
                end else begin
                    low_cnt_d = low_cnt_q + 1'b1;
                end
            end
            WAIT_RISE: begin
                if (busy_s_q) begin
                    state_d  = WAIT_FALL;
                    to_cnt_d = '0;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d     = IDLE;
                    timeout_evt = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            WAIT_FALL: begin
                if (!busy_s_q) begin
                    state_d = LATCH;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d     = IDLE;
                    timeout_evt = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            LATCH: begin
                // Two sync flops after BUSY fall give the parallel bus ample setup.
                new_sample = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d   = IDLE;
                cnvst_n_d = 1'b1;
            end
        endcase

        // A tick that lands while a conversion is in flight is lost; the counter keeps running.
        tick_miss = tick && (state_q != IDLE);

        xfer           = sample_valid_q && sample_ready;
        drop           = 1'b0;
        sample_data_d  = sample_data_q;
        sample_valid_d = sample_valid_q;
        if (new_sample) begin
            if (sample_valid_q && !sample_ready) begin
                drop = 1'b1;
            end else begin
                // Either empty or draining this cycle: the new sample takes the slot.
                sample_data_d  = conv_sample;
                sample_valid_d = 1'b1;
            end
        end else if (xfer) begin
            sample_valid_d = 1'b0;
        end

        // A same-cycle error event beats clear_err.
        overrun_d     = (overrun_q && !clear_err) || tick_miss || drop;
        timeout_err_d = (timeout_err_q && !clear_err) || timeout_evt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            ivl_cnt_q      <= '0;
            low_cnt_q      <= '0;
            to_cnt_q       <= '0;
            busy_meta_q    <= 1'b0;
            busy_s_q       <= 1'b0;
            cnvst_n_q      <= 1'b1;
            sample_data_q  <= '0;
            sample_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            ivl_cnt_q      <= ivl_cnt_d;
            low_cnt_q      <= low_cnt_d;
            to_cnt_q       <= to_cnt_d;
            busy_meta_q    <= busy_meta_d;
            busy_s_q       <= busy_s_d;
            cnvst_n_q      <= cnvst_n_d;
            sample_data_q  <= sample_data_d;
            sample_valid_q <= sample_valid_d;
            overrun_q      <= overrun_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    assign CNVST_N      = cnvst_n_q;
    assign sample_data  = sample_data_q;
    assign sample_valid = sample_valid_q;
    assign overrun      = overrun_q;
    assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_ad7673_conv_sequencer.sv
`timescale 1ns/1ps
// Bench for ad7673_conv_sequencer: table of ADC codes with expected offset-binary samples,
// plus hand sequences for backpressure, BUSY faults, missed ticks, reset and disable.
// A second instance with a long BUSY timeout covers a conversion that outlasts a tick.
module tb_ad7673_conv_sequencer;

    logic        clk = 1'b0;
    logic        reset, enable, enable2, clear_err, BUSY, sample_ready;
    logic [17:0] adc_data;
    logic        CNVST_N, sample_valid, overrun, timeout_err;
    logic [9:0]  sample_data;
    logic        cnvst_n2, sample_valid2, overrun2, timeout_err2;
    logic [9:0]  sample_data2;

    always #5 clk = ~clk;

    ad7673_conv_sequencer #(
        .SAMPLE_INTERVAL_CLK(50), .CNVST_LOW_CLK(4), .BUSY_TIMEOUT_CLK(20), .OUT_WIDTH(10)
    ) u_dut (
        .clk(clk), .reset(reset), .enable(enable), .clear_err(clear_err), .BUSY(BUSY),
        .AD7673_DATA(adc_data), .CNVST_N(CNVST_N), .sample_data(sample_data),
        .sample_valid(sample_valid), .sample_ready(sample_ready), .overrun(overrun),
        .timeout_err(timeout_err)
    );

    ad7673_conv_sequencer #(
        .SAMPLE_INTERVAL_CLK(50), .CNVST_LOW_CLK(4), .BUSY_TIMEOUT_CLK(200), .OUT_WIDTH(10)
    ) u_dut_long (
        .clk(clk), .reset(reset), .enable(enable2), .clear_err(clear_err), .BUSY(BUSY),
        .AD7673_DATA(adc_data), .CNVST_N(cnvst_n2), .sample_data(sample_data2),
        .sample_valid(sample_valid2), .sample_ready(sample_ready), .overrun(overrun2),
        .timeout_err(timeout_err2)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // ADC model: BUSY rises 3 cycles after a CNVST_N fall and stays high busy_len cycles.
    // busy_mode 1 = stuck low, 2 = stuck high.
    int   busy_mode = 0;
    int   busy_len  = 10;
    int   rise_dly  = 0;
    int   hold      = 0;
    logic cnv_prev  = 1'b1;
    logic cnv_now;

    initial begin
        BUSY = 1'b0;
        forever begin
            @(negedge clk);
            cnv_now = CNVST_N & cnvst_n2;
            if (busy_mode == 1) begin
                BUSY = 1'b0; rise_dly = 0; hold = 0;
            end else if (busy_mode == 2) begin
                BUSY = 1'b1; rise_dly = 0; hold = 0;
            end else begin
                if (hold > 0) begin
                    hold--;
                    if (hold == 0) BUSY = 1'b0;
                end else if (BUSY) begin
                    BUSY = 1'b0;
                end
                if (rise_dly > 0) begin
                    rise_dly--;
                    if (rise_dly == 0) begin
                        BUSY = 1'b1;
                        hold = busy_len;
                    end
                end
                if (cnv_prev && !cnv_now) rise_dly = 3;
            end
            cnv_prev = cnv_now;
        end
    end

    // Pulse monitor on the main instance: low width, fall-to-fall period, transfer count.
    int   cyc = 0, low_run = 0, last_low = 0, last_period = 0, last_fall = 0;
    int   pulses = 0, xfers = 0;
    logic cn_prev = 1'b1;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!CNVST_N) low_run++;
            if (cn_prev && !CNVST_N) begin
                if (pulses > 0) last_period = cyc - last_fall;
                last_fall = cyc;
                pulses++;
            end
            if (!cn_prev && CNVST_N) begin
                last_low = low_run;
                low_run  = 0;
            end
            if (sample_valid && sample_ready) xfers++;
            cn_prev = CNVST_N;
        end
    end

    task automatic wait_sample(input bit sel, output logic [9:0] d, output bit got, output int lows);
        got = 1'b0; lows = 0; d = '0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if ((sel ? cnvst_n2 : CNVST_N) == 1'b0) lows++;
            if (sel ? sample_valid2 : sample_valid) begin
                got = 1'b1;
                d   = sel ? sample_data2 : sample_data;
            end
        end
    endtask

    task automatic wait_fall(input bit sel, output bit got);
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if ((sel ? cnvst_n2 : CNVST_N) == 1'b0) got = 1'b1;
        end
    endtask

    typedef struct {
        logic [17:0] data;
        logic [9:0]  exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] d;
        bit         got;
        int         lows, p0, x0, bad, seen_v;

        vecs[0] = '{18'h1FFFF, 10'h3FF};
        vecs[1] = '{18'h20000, 10'h000};
        vecs[2] = '{18'h00000, 10'h200};
        vecs[3] = '{18'h3FFFF, 10'h1FF};
        vecs[4] = '{18'h10000, 10'h300};
        vecs[5] = '{18'h2FFFF, 10'h0FF};
        vecs[6] = '{18'h000FF, 10'h200};
        vecs[7] = '{18'h00100, 10'h201};

        reset = 1'b1; enable = 1'b0; enable2 = 1'b0; clear_err = 1'b0;
        sample_ready = 1'b1; adc_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_cnvst_n", CNVST_N, 1'b1);
        chk("rst_valid", sample_valid, 1'b0);
        chk("rst_data", sample_data, 10'h000);
        chk("rst_overrun", overrun, 1'b0);
        chk("rst_timeout", timeout_err, 1'b0);
        reset = 1'b0;

        // Nominal conversions and code mapping
        p0 = pulses; x0 = xfers;
        adc_data = vecs[0].data;
        enable   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wait_sample(1'b0, d, got, lows);
            chk($sformatf("vec%0d_seen", i), got, 1'b1);
            chk($sformatf("vec%0d_data", i), d, vecs[i].exp);
            if (i < 7) adc_data = vecs[i+1].data;
        end
        @(negedge clk);
        chk("nom_low_width", last_low, 4);
        chk("nom_period", last_period, 50);
        chk("nom_one_valid_per_tick", xfers - x0, pulses - p0);
        chk("nom_overrun", overrun, 1'b0);
        chk("nom_timeout", timeout_err, 1'b0);

        // Backpressure: first sample held, later ones dropped
        sample_ready = 1'b0;
        adc_data     = 18'h0ABCD;
        wait_sample(1'b0, d, got, lows);
        chk("bp_first_seen", got, 1'b1);
        chk("bp_first_data", d, 10'h2AB);
        adc_data = 18'h3FFFF;
        bad = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (!(sample_valid === 1'b1 && sample_data === 10'h2AB)) bad++;
        end
        chk("bp_held_stable", bad, 0);
        chk("bp_overrun", overrun, 1'b1);
        sample_ready = 1'b1;
        @(negedge clk);
        chk("bp_drained", sample_valid, 1'b0);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        chk("bp_clear_overrun", overrun, 1'b0);

        // BUSY stuck low: timeout 20 cycles after WAIT_RISE entry; error beats clear_err
        busy_mode = 1;
        wait_fall(1'b0, got);
        chk("sl_fall_seen", got, 1'b1);
        repeat (23) @(negedge clk);
        chk("sl_timeout_early", timeout_err, 1'b0);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        chk("sl_timeout_set", timeout_err, 1'b1);
        chk("sl_no_valid", sample_valid, 1'b0);
        busy_mode = 0;
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        chk("sl_timeout_cleared", timeout_err, 1'b0);
        adc_data = 18'h10000;
        wait_sample(1'b0, d, got, lows);
        chk("sl_recover_seen", got, 1'b1);
        chk("sl_recover_data", d, 10'h300);

        // BUSY stuck high: timeout in WAIT_FALL, no sample
        busy_mode = 2;
        wait_fall(1'b0, got);
        chk("sh_fall_seen", got, 1'b1);
        seen_v = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (sample_valid) seen_v++;
        end
        chk("sh_timeout_early", timeout_err, 1'b0);
        @(negedge clk);
        chk("sh_timeout_set", timeout_err, 1'b1);
        chk("sh_no_valid", seen_v, 0);
        busy_mode = 0;
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        enable    = 1'b0;

        // 80-cycle BUSY on the long-timeout instance: tick mid-conversion is discarded
        busy_len = 80;
        adc_data = 18'h00100;
        enable2  = 1'b1;
        wait_fall(1'b1, got);
        chk("long_fall_seen", got, 1'b1);
        wait_sample(1'b1, d, got, lows);
        enable2  = 1'b0;
        busy_len = 10;
        chk("long_seen", got, 1'b1);
        chk("long_data", d, 10'h201);
        chk("long_no_extra_pulse", lows, 3);
        chk("long_overrun", overrun2, 1'b1);
        chk("long_timeout", timeout_err2, 1'b0);

        // Reset during CONV_LOW with a held sample and overrun pending
        sample_ready = 1'b0;
        adc_data     = 18'h1FFFF;
        enable       = 1'b1;
        wait_sample(1'b0, d, got, lows);
        chk("rc_seen", got, 1'b1);
        chk("rc_data", d, 10'h3FF);
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (overrun) got = 1'b1;
        end
        chk("rc_overrun", got, 1'b1);
        wait_fall(1'b0, got);
        chk("rc_fall_seen", got, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        chk("rc_cnvst_n", CNVST_N, 1'b1);
        chk("rc_valid", sample_valid, 1'b0);
        chk("rc_data_zero", sample_data, 10'h000);
        chk("rc_overrun_zero", overrun, 1'b0);
        chk("rc_timeout_zero", timeout_err, 1'b0);
        reset        = 1'b0;
        sample_ready = 1'b1;
        adc_data     = 18'h2FFFF;

        // First tick on the 50th enabled cycle after reset
        repeat (49) @(negedge clk);
        chk("first_tick_not_yet", CNVST_N, 1'b1);
        @(negedge clk);
        chk("first_tick_low", CNVST_N, 1'b0);

        // Drop enable during WAIT_FALL: sample still delivered, no further pulses
        repeat (8) @(negedge clk);
        enable = 1'b0;
        wait_sample(1'b0, d, got, lows);
        chk("dis_seen", got, 1'b1);
        chk("dis_data", d, 10'h0FF);
        lows = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (!CNVST_N) lows++;
        end
        chk("dis_no_pulses", lows, 0);
        chk("dis_overrun", overrun, 1'b0);
        chk("dis_timeout", timeout_err, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
